forward_hazard_ctrl: RTL and testbench

FORWARD_HAZARD_CTRL -- requirements
Module: forward_hazard_ctrl

---
 rtl/forward_hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_forward_hazard_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/forward_hazard_ctrl.sv
// Forwarding-select and load-use hazard controller for a 5-stage pipeline.
// Latency: selects and stall_cnt registered (valid the cycle the instruction is in EX); stall/enables combinational.
// Backpressure: hold freezes all state and gates pc_we/ifid_we/idex_flush low; stall gates PC/IF-ID for one cycle.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   hold                       global freeze (memory wait)
//   dec_valid, dec_rs, dec_rt, dec_use_rs, dec_use_rt, dec_rd,
//   dec_reg_write, dec_mem_read    decode-stage instruction fields
//   flush                      taken branch, kills the decode instruction
//   fwd_a_sel, fwd_b_sel       ALU operand selects: 00 regfile, 01 MEM/WB, 10 EX/MEM
//   stall                      load-use hazard (combinational)
//   pc_we, ifid_we, idex_flush pipeline register controls
//   stall_cnt                  saturating count of stall cycles
module forward_hazard_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold,
    input  logic        dec_valid,
    input  logic [4:0]  dec_rs,
    input  logic [4:0]  dec_rt,
    input  logic        dec_use_rs,
    input  logic        dec_use_rt,
    input  logic [4:0]  dec_rd,
    input  logic        dec_reg_write,
    input  logic        dec_mem_read,
    input  logic        flush,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        stall,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_flush,
    output logic [15:0] stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_EX  = 2'b10;

    // Shadow of the instructions currently in EX and MEM.
    logic       ex_valid;
    logic [4:0] ex_rd;
    logic       ex_reg_write;
    logic       ex_mem_read;
    logic       mem_valid;
    logic [4:0] mem_rd;
    logic       mem_reg_write;

    logic       ex_hit_rs;
    logic       ex_hit_rt;
    logic       mem_hit_rs;
    logic       mem_hit_rt;
    logic       load_dec;
    logic [1:0] next_a;
    logic [1:0] next_b;

    // A stage produces a source only if it really writes a non-zero register.
    assign ex_hit_rs  = ex_valid  & ex_reg_write  & (ex_rd  != 5'd0) & (ex_rd  == dec_rs);
    assign ex_hit_rt  = ex_valid  & ex_reg_write  & (ex_rd  != 5'd0) & (ex_rd  == dec_rt);
    assign mem_hit_rs = mem_valid & mem_reg_write & (mem_rd != 5'd0) & (mem_rd == dec_rs);
    assign mem_hit_rt = mem_valid & mem_reg_write & (mem_rd != 5'd0) & (mem_rd == dec_rt);

    // A load in EX cannot feed the next instruction; flush wins over stall
    // because the consumer is being killed anyway.
    assign stall = dec_valid & ~flush & ex_mem_read &
                   ((dec_use_rs & ex_hit_rs) | (dec_use_rt & ex_hit_rt));

    assign load_dec   = dec_valid & ~stall & ~flush;
    assign pc_we      = ~stall & ~hold;
    assign ifid_we    = ~stall & ~hold;
    assign idex_flush = (stall | flush) & ~hold;

    // EX is the newest producer, so it is checked first. A load in EX falls
    // through to MEM; the stall path turns that case into a bubble anyway.
    always_comb begin
        next_a = SEL_RF;
        if (dec_use_rs && ex_hit_rs && !ex_mem_read) begin
            next_a = SEL_EX;
        end else if (mem_hit_rs) begin
            next_a = SEL_MEM;
        end
    end

    always_comb begin
        next_b = SEL_RF;
        if (dec_use_rt && ex_hit_rt && !ex_mem_read) begin
            next_b = SEL_EX;
        end else if (mem_hit_rt) begin
            next_b = SEL_MEM;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid      <= 1'b0;
            ex_rd         <= 5'd0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            mem_valid     <= 1'b0;
            mem_rd        <= 5'd0;
            mem_reg_write <= 1'b0;
            fwd_a_sel     <= SEL_RF;
            fwd_b_sel     <= SEL_RF;
            stall_cnt     <= 16'd0;
        end else if (!hold) begin
            mem_valid     <= ex_valid;
            mem_rd        <= ex_rd;
            mem_reg_write <= ex_reg_write;
            ex_valid      <= load_dec;
            ex_rd         <= load_dec ? dec_rd : 5'd0;
            ex_reg_write  <= load_dec & dec_reg_write;
            ex_mem_read   <= load_dec & dec_mem_read;
            fwd_a_sel     <= load_dec ? next_a : SEL_RF;
            fwd_b_sel     <= load_dec ? next_b : SEL_RF;
            if (stall && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_forward_hazard_ctrl.sv
module tb_forward_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n, hold, dec_valid, dec_use_rs, dec_use_rt;
    logic [4:0]  dec_rs, dec_rt, dec_rd;
    logic        dec_reg_write, dec_mem_read, flush;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic        stall, pc_we, ifid_we, idex_flush;
    logic [15:0] stall_cnt;

    forward_hazard_ctrl dut (
        .clk(clk), .rst_n(rst_n), .hold(hold), .dec_valid(dec_valid),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_use_rs(dec_use_rs),
        .dec_use_rt(dec_use_rt), .dec_rd(dec_rd), .dec_reg_write(dec_reg_write),
        .dec_mem_read(dec_mem_read), .flush(flush), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .stall(stall), .pc_we(pc_we), .ifid_we(ifid_we),
        .idex_flush(idex_flush), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: list of instructions in flight after decode, newest first.
    typedef struct { bit valid; bit [4:0] rd; bit rw; bit mr; } instr_t;
    typedef struct { bit [1:0] a; bit [1:0] b; bit st; bit pcwe; bit ifwe; bit idf; bit [15:0] cnt; } exp_t;

    instr_t      flight[$];
    exp_t        sbq[$];
    int unsigned m_cnt;
    bit [1:0]    m_a, m_b;
    int          total = 0;
    int          bad = 0;
    bit          preload_req = 1'b0;
    bit [15:0]   preload_val = 16'd0;

    function automatic bit produces(instr_t p, bit [4:0] src);
        return p.valid && p.rw && (p.rd != 5'd0) && (p.rd == src);
    endfunction

    // Newest producer wins; a load one instruction ahead cannot be forwarded.
    function automatic bit [1:0] pick(bit [4:0] src, bit use_src);
        for (int i = 0; i < 2; i++) begin
            if (produces(flight[i], src)) begin
                if (i == 0 && use_src && !flight[i].mr) return 2'b10;
                if (i == 1) return 2'b01;
            end
        end
        return 2'b00;
    endfunction

    task automatic clear_model();
        instr_t bub;
        bub = '{valid: 1'b0, rd: 5'd0, rw: 1'b0, mr: 1'b0};
        flight.delete();
        flight.push_back(bub);
        flight.push_back(bub);
        m_a = 2'b00;
        m_b = 2'b00;
        m_cnt = 0;
    endtask

    task automatic cyc(input bit rstn, input bit hld, input bit vld,
                       input bit [4:0] rs, input bit [4:0] rt, input bit urs, input bit urt,
                       input bit [4:0] rd, input bit rw, input bit mr, input bit fl);
        exp_t   e;
        instr_t ni;
        bit     st;
        bit     take;
        @(posedge clk);
        #1;
        if (preload_req) begin
            force dut.stall_cnt = preload_val;
            #0;
            release dut.stall_cnt;
            m_cnt = preload_val;
            preload_req = 1'b0;
        end
        rst_n = rstn; hold = hld; dec_valid = vld; dec_rs = rs; dec_rt = rt;
        dec_use_rs = urs; dec_use_rt = urt; dec_rd = rd; dec_reg_write = rw;
        dec_mem_read = mr; flush = fl;
        st = vld && !fl && flight[0].mr &&
             ((urs && produces(flight[0], rs)) || (urt && produces(flight[0], rt)));
        e.a = m_a; e.b = m_b; e.st = st;
        e.pcwe = !st && !hld; e.ifwe = !st && !hld; e.idf = (st || fl) && !hld;
        e.cnt = m_cnt[15:0];
        sbq.push_back(e);
        if (!rstn) begin
            clear_model();
        end else if (!hld) begin
            take = vld && !st && !fl;
            if (st && m_cnt < 65535) m_cnt++;
            m_a = take ? pick(rs, urs) : 2'b00;
            m_b = take ? pick(rt, urt) : 2'b00;
            ni = '{valid: take, rd: rd, rw: take && rw, mr: take && mr};
            flight.push_front(ni);
            void'(flight.pop_back());
        end
    endtask

    task automatic idle();
        cyc(1, 0, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    endtask

    task automatic ins(input bit [4:0] rs, input bit [4:0] rt, input bit urs, input bit urt,
                       input bit [4:0] rd, input bit rw, input bit mr);
        cyc(1, 0, 1, rs, rt, urs, urt, rd, rw, mr, 0);
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, want, $time);
        end
    endtask

    // Monitor: compare whatever the DUT presents against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            check("fwd_a_sel", {14'd0, fwd_a_sel}, {14'd0, e.a});
            check("fwd_b_sel", {14'd0, fwd_b_sel}, {14'd0, e.b});
            check("stall", {15'd0, stall}, {15'd0, e.st});
            check("pc_we", {15'd0, pc_we}, {15'd0, e.pcwe});
            check("ifid_we", {15'd0, ifid_we}, {15'd0, e.ifwe});
            check("idex_flush", {15'd0, idex_flush}, {15'd0, e.idf});
            check("stall_cnt", stall_cnt, e.cnt);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 0; hold = 0; dec_valid = 0; dec_rs = 0; dec_rt = 0; dec_use_rs = 0;
        dec_use_rt = 0; dec_rd = 0; dec_reg_write = 0; dec_mem_read = 0; flush = 0;
        repeat (2) @(posedge clk);
        clear_model();
        // Reset with hold and flush also asserted: reset must still win.
        cyc(0, 1, 1, 5'd1, 5'd1, 1, 1, 5'd1, 1, 1, 1);
        idle();

        // ALU back-to-back.
        ins(5'd0, 5'd0, 0, 0, 5'd5, 1, 0);
        ins(5'd5, 5'd6, 1, 1, 5'd8, 1, 0);
        idle(); idle();

        // Distance two, then EX-over-MEM priority.
        ins(5'd0, 5'd0, 0, 0, 5'd7, 1, 0);
        ins(5'd1, 5'd2, 1, 1, 5'd9, 1, 0);
        ins(5'd0, 5'd7, 0, 1, 5'd10, 1, 0);
        ins(5'd0, 5'd0, 0, 0, 5'd7, 1, 0);
        ins(5'd0, 5'd0, 0, 0, 5'd7, 1, 0);
        ins(5'd0, 5'd7, 0, 1, 5'd10, 1, 0);
        idle(); idle();

        // Load-use: stall once, then re-presented add forwards from MEM.
        ins(5'd0, 5'd0, 0, 0, 5'd3, 1, 1);
        ins(5'd3, 5'd4, 1, 1, 5'd11, 1, 0);
        ins(5'd3, 5'd4, 1, 1, 5'd11, 1, 0);
        idle(); idle();

        // Register zero never forwarded or stalled on.
        ins(5'd0, 5'd0, 0, 0, 5'd0, 1, 0);
        ins(5'd0, 5'd0, 1, 1, 5'd12, 1, 0);
        ins(5'd0, 5'd0, 0, 0, 5'd0, 1, 1);
        ins(5'd0, 5'd0, 1, 1, 5'd12, 1, 0);
        idle(); idle();

        // Hold for three cycles in the middle of a load-use hazard.
        ins(5'd0, 5'd0, 0, 0, 5'd3, 1, 1);
        repeat (3) cyc(1, 1, 1, 5'd3, 5'd0, 1, 0, 5'd13, 1, 0, 0);
        ins(5'd3, 5'd0, 1, 0, 5'd13, 1, 0);
        ins(5'd3, 5'd0, 1, 0, 5'd13, 1, 0);
        idle(); idle();

        // Flush on top of a hazard.
        ins(5'd0, 5'd0, 0, 0, 5'd3, 1, 1);
        cyc(1, 0, 1, 5'd3, 5'd3, 1, 1, 5'd14, 1, 0, 1);
        idle(); idle();

        // Counter saturation from a preloaded value, repeated dependent loads.
        idle();
        preload_val = 16'hFFF8;
        preload_req = 1'b1;
        repeat (24) ins(5'd3, 5'd0, 1, 0, 5'd3, 1, 1);

        // Reset mid-stall drops the load; no stall afterwards.
        ins(5'd0, 5'd0, 0, 0, 5'd3, 1, 1);
        cyc(0, 0, 1, 5'd3, 5'd0, 1, 0, 5'd15, 1, 0, 0);
        ins(5'd3, 5'd0, 1, 0, 5'd15, 1, 0);
        idle(); idle();

        // Randomized traffic over a small register set to force collisions.
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 99) >= 2), ($urandom_range(0, 99) < 10),
                ($urandom_range(0, 99) < 80),
                5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 70),
                ($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 10));
        end
        idle();
        @(posedge clk);
        @(negedge clk);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
